// File: rtl/ysyx_22040931_redirect_ctrl_pkg.sv
// Shared types and constants for the branch/jump redirect sequencer.
// Holds the FSM state encoding, datapath width, reset PC and the taken decode.
package ysyx_22040931_redirect_ctrl_pkg;

    localparam int          DATA_BUS       = 64;
    localparam logic [63:0] RST_PC_DEFAULT = 64'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REDIR = 2'd2
    } redir_state_e;

    function automatic logic is_taken(
        input logic valid,
        input logic btype,
        input logic jump,
        input logic is_jal,
        input logic is_jalr
    );
        return valid & ((btype & jump) | is_jal | is_jalr);
    endfunction

endpackage

// File: rtl/ysyx_22040931_redirect_ctrl_if.sv
// EX-stage branch inputs, IFU handshake and front-end control bundle.
// master = pipeline/IFU side, slave = redirect controller.
interface ysyx_22040931_redirect_ctrl_if #(
    parameter int XLEN = 64
);
    logic            ex_valid;
    logic            ex_btype;
    logic            ex_jump;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic            ifu_inflight;
    logic            ifu_rvalid;
    logic            ifu_ready;
    logic            fe_flush;
    logic            fe_stall;
    logic            drop_resp;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            exc_misalign;

    modport master (
        output ex_valid, ex_btype, ex_jump, ex_is_jal, ex_is_jalr,
        output ex_pc, ex_imm, ex_rs1,
        output ifu_inflight, ifu_rvalid, ifu_ready,
        input  fe_flush, fe_stall, drop_resp, redir_valid, redir_pc, exc_misalign
    );

    modport slave (
        input  ex_valid, ex_btype, ex_jump, ex_is_jal, ex_is_jalr,
        input  ex_pc, ex_imm, ex_rs1,
        input  ifu_inflight, ifu_rvalid, ifu_ready,
        output fe_flush, fe_stall, drop_resp, redir_valid, redir_pc, exc_misalign
    );
endinterface

// File: rtl/ysyx_22040931_redirect_target.sv
// Combinational redirect target: pc+imm for branch/JAL, (rs1+imm)&~1 for JALR.
// Zero latency; flags targets that are not 4-byte aligned.
module ysyx_22040931_redirect_target #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_jalr,
    output logic [XLEN-1:0] target,
    output logic            misalign
);
    logic [XLEN-1:0] pc_sum;
    logic [XLEN-1:0] rs1_sum;

    assign pc_sum  = pc + imm;
    assign rs1_sum = rs1 + imm;

    always_comb begin
        target = pc_sum;
        if (is_jalr) begin
            target = {rs1_sum[XLEN-1:1], 1'b0};
        end
    end

    // bit0 is either architecturally zero or cleared above, so bit1 decides.
    assign misalign = target[1];
endmodule

// File: rtl/ysyx_22040931_redirect_ctrl.sv
// Redirect sequencer: taken branch/JAL/JALR -> flush, drain stale fetch, hold redirect until IFU ready.
// Flush same cycle, redir_valid next cycle (later if a fetch is in flight); holds while ifu_ready low.
// Optional YSYX_22040931_BRANCH_PERF_EN adds branch / taken / stall counters.
module ysyx_22040931_redirect_ctrl
    import ysyx_22040931_redirect_ctrl_pkg::*;
#(
    parameter int              XLEN   = DATA_BUS,
    parameter logic [XLEN-1:0] RST_PC = RST_PC_DEFAULT[XLEN-1:0]
) (
    input  logic                            clk,
    input  logic                            rst_n,
    ysyx_22040931_redirect_ctrl_if.slave    bus
`ifdef YSYX_22040931_BRANCH_PERF_EN
    ,
    output logic [XLEN-1:0]                 perf_br,
    output logic [XLEN-1:0]                 perf_taken,
    output logic [XLEN-1:0]                 perf_stall
`endif
);
    redir_state_e    state_q, state_d;
    logic [XLEN-1:0] redir_pc_q;
    logic [XLEN-1:0] target;
    logic            misalign;
    logic            taken;
    logic            load_pc;
    logic            flush;
    logic            stall;
    logic            drop;
    logic            rvld;
    logic            exc;

    ysyx_22040931_redirect_target #(.XLEN(XLEN)) u_target (
        .pc       (bus.ex_pc),
        .imm      (bus.ex_imm),
        .rs1      (bus.ex_rs1),
        .is_jalr  (bus.ex_is_jalr),
        .target   (target),
        .misalign (misalign)
    );

    assign taken = is_taken(bus.ex_valid, bus.ex_btype, bus.ex_jump,
                            bus.ex_is_jal, bus.ex_is_jalr);

    always_comb begin
        state_d = state_q;
        load_pc = 1'b0;
        flush   = 1'b0;
        stall   = 1'b0;
        drop    = 1'b0;
        rvld    = 1'b0;
        exc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Misaligned targets trap instead of redirecting.
                if (taken && misalign) begin
                    exc = 1'b1;
                end else if (taken) begin
                    flush   = 1'b1;
                    load_pc = 1'b1;
                    state_d = bus.ifu_inflight ? ST_DRAIN : ST_REDIR;
                end
            end
            ST_DRAIN: begin
                flush = 1'b1;
                stall = 1'b1;
                drop  = bus.ifu_rvalid;
                if (bus.ifu_rvalid) begin
                    state_d = ST_REDIR;
                end
            end
            ST_REDIR: begin
                flush = 1'b1;
                stall = 1'b1;
                rvld  = 1'b1;
                if (bus.ifu_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            redir_pc_q <= RST_PC;
        end else begin
            state_q <= state_d;
            if (load_pc) begin
                redir_pc_q <= target;
            end
        end
    end

    assign bus.fe_flush     = flush;
    assign bus.fe_stall     = stall;
    assign bus.drop_resp    = drop;
    assign bus.redir_valid  = rvld;
    assign bus.redir_pc     = redir_pc_q;
    assign bus.exc_misalign = exc;

`ifdef YSYX_22040931_BRANCH_PERF_EN
    logic is_br;
    assign is_br = (state_q == ST_IDLE) && bus.ex_valid && bus.ex_btype;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br    <= '0;
            perf_taken <= '0;
            perf_stall <= '0;
        end else begin
            if (is_br) begin
                perf_br <= perf_br + 1'b1;
            end
            if (is_br && bus.ex_jump) begin
                perf_taken <= perf_taken + 1'b1;
            end
            if (state_q != ST_IDLE) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif
endmodule
